// File: rtl/two_wire_rx.sv
// two_wire_rx: serial frame receiver for the two-wire strobe/data link.
// A frame is a sequence of qualified bits (in1=1):
//   start (in2=0), DATA_W data bits MSB first, optional even-parity bit,
//   stop (in2=1).
// A stall of TIMEOUT consecutive unqualified cycles mid-frame aborts it.
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-low reset
//   in1        in   bit strobe; in2 is sampled only when in1=1
//   in2        in   serial bit value
//   data       out  last good word, updated only on a good stop bit
//   data_valid out  one-cycle pulse, data holds a new word
//   par_err    out  parity mismatch, meaningful only with data_valid
//   frame_err  out  one-cycle pulse on bad stop bit or stall timeout
//   busy       out  receiver is inside a frame
module two_wire_rx #(
  parameter int unsigned DATA_W    = 8,
  parameter bit          PARITY_EN = 1'b1,
  parameter int unsigned TIMEOUT   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in1,
  input  logic              in2,
  output logic [DATA_W-1:0] data,
  output logic              data_valid,
  output logic              par_err,
  output logic              frame_err,
  output logic              busy
);

  localparam int unsigned CNT_W   = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int unsigned STALL_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
    S_PARITY = 2'd2,
    S_STOP   = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [STALL_W-1:0]  stall_q, stall_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic                par_bit_q, par_bit_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                data_valid_q, data_valid_d;
  logic                par_err_q, par_err_d;
  logic                frame_err_q, frame_err_d;
  logic                busy_q, busy_d;

  logic [STALL_W-1:0]  stall_inc_c;
  logic                parity_bad_c;

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      bit_cnt_q    <= '0;
      stall_q      <= '0;
      shift_q      <= '0;
      par_bit_q    <= 1'b0;
      data_q       <= '0;
      data_valid_q <= 1'b0;
      par_err_q    <= 1'b0;
      frame_err_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      stall_q      <= stall_d;
      shift_q      <= shift_d;
      par_bit_q    <= par_bit_d;
      data_q       <= data_d;
      data_valid_q <= data_valid_d;
      par_err_q    <= par_err_d;
      frame_err_q  <= frame_err_d;
      busy_q       <= busy_d;
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    stall_d      = stall_q;
    shift_d      = shift_q;
    par_bit_d    = par_bit_q;
    data_d       = data_q;
    data_valid_d = 1'b0;
    par_err_d    = 1'b0;
    frame_err_d  = 1'b0;

    stall_inc_c  = stall_q + STALL_W'(1);
    // Even parity: data bits plus parity bit must XOR to zero.
    parity_bad_c = PARITY_EN ? ((^shift_q) ^ par_bit_q) : 1'b0;

    if ((state_q != S_IDLE) && !in1) begin
      // Stall mid-frame: abort once the TIMEOUT-th consecutive stall is seen.
      if (stall_inc_c == STALL_W'(TIMEOUT)) begin
        state_d     = S_IDLE;
        stall_d     = '0;
        bit_cnt_d   = '0;
        shift_d     = '0;
        frame_err_d = 1'b1;
      end else begin
        stall_d = stall_inc_c;
      end
    end else begin
      stall_d = '0;
      case (state_q)
        S_IDLE: begin
          // in1=1 with in2=1 is line idle and ignored.
          if (in1 && !in2) begin
            state_d   = S_DATA;
            bit_cnt_d = '0;
          end
        end
        S_DATA: begin
          shift_d   = {shift_q[DATA_W-2:0], in2};
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
          if (bit_cnt_q == CNT_W'(DATA_W - 1)) begin
            bit_cnt_d = '0;
            state_d   = PARITY_EN ? S_PARITY : S_STOP;
          end
        end
        S_PARITY: begin
          par_bit_d = in2;
          state_d   = S_STOP;
        end
        S_STOP: begin
          state_d = S_IDLE;
          if (in2) begin
            data_d       = shift_q;
            data_valid_d = 1'b1;
            par_err_d    = parity_bad_c;
          end else begin
            frame_err_d = 1'b1;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end

    busy_d = (state_d != S_IDLE);
  end

  assign data       = data_q;
  assign data_valid = data_valid_q;
  assign par_err    = par_err_q;
  assign frame_err  = frame_err_q;
  assign busy       = busy_q;

endmodule
